// File: rtl/mult_stim_driver.sv
// mult_stim_driver: FIFO-buffered start/done stimulus driver for the shift-add multiplier.
// Optional MULT_DRV_CHECK_EN registers op1*op2 at dispatch and flags mismatching products.
module mult_stim_driver #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_op1,
    input  logic [WIDTH-1:0]   req_op2,
    input  logic               mult_ready,
    output logic               mult_start,
    output logic [WIDTH-1:0]   mult_multiplicand,
    output logic [WIDTH-1:0]   mult_multiplier,
    input  logic               mult_done,
    input  logic [2*WIDTH-1:0] mult_product,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               rsp_timeout,
    output logic               rsp_mismatch,
    output logic [15:0]        txn_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   fifo1_q [DEPTH];
    logic [WIDTH-1:0]   fifo2_q [DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q;
    logic [WIDTH-1:0]   op1_q, op2_q;
    logic [CW-1:0]      tmr_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               tmo_q;
    logic [15:0]        txn_q;
    logic               push, pop, tmr_end;

    // Held low during reset so nothing is accepted until it deasserts.
    assign req_ready         = !reset && cnt_q != (AW+1)'(DEPTH);
    assign push              = req_valid && req_ready;
    assign tmr_end           = tmr_q == CW'(TIMEOUT - 1);
    assign mult_multiplicand = op1_q;
    assign mult_multiplier   = op2_q;
    assign rsp_product       = prod_q;
    assign rsp_timeout       = tmo_q;
    assign txn_count         = txn_q;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        mult_start = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: if (cnt_q != '0 && mult_ready) begin
                pop     = 1'b1;
                state_d = START;
            end
            START: begin
                mult_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: if (mult_done || tmr_end) state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo1_q[wr_q] <= req_op1;
            fifo2_q[wr_q] <= req_op2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            tmr_q   <= '0;
            prod_q  <= '0;
            tmo_q   <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) begin
                rd_q  <= rd_q + AW'(1);
                op1_q <= fifo1_q[rd_q];
                op2_q <= fifo2_q[rd_q];
            end
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            if (state_q == START) tmr_q <= '0;
            else if (state_q == WAIT) tmr_q <= tmr_q + CW'(1);
            // Done takes priority over a timeout landing in the same cycle.
            if (state_q == WAIT && mult_done) begin
                prod_q <= mult_product;
                tmo_q  <= 1'b0;
            end else if (state_q == WAIT && tmr_end) begin
                prod_q <= '0;
                tmo_q  <= 1'b1;
            end
            if (state_q == RESP && rsp_ready) txn_q <= txn_q + 16'd1;
        end
    end

`ifdef MULT_DRV_CHECK_EN
    logic [2*WIDTH-1:0] exp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) exp_q <= '0;
        else if (pop) exp_q <= (2*WIDTH)'(fifo1_q[rd_q]) * (2*WIDTH)'(fifo2_q[rd_q]);
    end

    assign rsp_mismatch = rsp_valid && !tmo_q && prod_q != exp_q;
`else
    assign rsp_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_mult_stim_driver.sv
// tb_mult_stim_driver: randomized and directed bench for mult_stim_driver against a
// timestamp-based transaction model; the bench also plays the multiplier.
module tb_mult_stim_driver;
    localparam int W = 8;
    localparam int D = 4;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_op1 = '0;
    logic [7:0]  req_op2 = '0;
    logic        mult_ready = 1'b0;
    logic        mult_done = 1'b0;
    logic [15:0] mult_product = '0;
    logic        rsp_ready = 1'b0;
    logic        req_ready, mult_start, rsp_valid, rsp_timeout, rsp_mismatch;
    logic [7:0]  mult_multiplicand, mult_multiplier;
    logic [15:0] rsp_product, txn_count;

    always #5 clk = ~clk;

    mult_stim_driver #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op1(req_op1), .req_op2(req_op2),
        .mult_ready(mult_ready), .mult_start(mult_start),
        .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
        .mult_done(mult_done), .mult_product(mult_product),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
        .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch), .txn_count(txn_count)
    );

    typedef struct {logic [7:0] a; logic [7:0] b;} pair_t;

    int passed = 0, total = 0, e = 0;
    pair_t q[$];
    bit busy = 1'b0, exp_tmo = 1'b0, spurious_en = 1'b0;
    int d_edge = -100, resp_edge = -100, done_edge = -100;
    logic [7:0] cur_a = '0, cur_b = '0;
    logic [15:0] exp_prod = '0, plan_prod = '0, txn = '0;
    int fixed_lat = -1, fixed_prod = -1;
    int n_start = 0, first_start_e = -1, first_valid_e = -1, push_e = 0;
    logic [15:0] last_prod = '0;
    logic last_tmo = 1'b0, last_mm = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
        else passed++;
    endtask

    function automatic int pick_lat();
        int r;
        if (fixed_lat >= 0) return fixed_lat;
        r = int'($urandom_range(0, 19));
        if (r < 14) return int'($urandom_range(1, 12));
        if (r == 14) return T;
        if (r == 15) return T - 1;
        if (r < 18) return T + 5;
        return 1;
    endfunction

    // A transaction dispatched at edge d shows start in the following cycle, leaves START
    // at d+1, and responds at the done edge or at d+1+T, whichever comes first.
    task automatic dispatch();
        pair_t p;
        int lat;
        p = q.pop_front();
        lat = pick_lat();
        cur_a = p.a;
        cur_b = p.b;
        d_edge = e;
        busy = 1'b1;
        plan_prod = 16'(p.a) * 16'(p.b);
        if (fixed_prod >= 0) plan_prod = 16'(fixed_prod);
        else if (fixed_lat < 0 && $urandom_range(0, 7) == 0) plan_prod = plan_prod ^ 16'($urandom_range(1, 65535));
        if (lat <= T) begin
            done_edge = e + 1 + lat;
            resp_edge = done_edge;
            exp_tmo = 1'b0;
            exp_prod = plan_prod;
        end else begin
            done_edge = -100;
            resp_edge = e + 1 + T;
            exp_tmo = 1'b1;
            exp_prod = '0;
        end
    endtask

    task automatic model_edge();
        bit can_push;
        can_push = q.size() < D;
        if (!busy) begin
            if (q.size() > 0 && mult_ready) dispatch();
        end else if (e > resp_edge && rsp_ready) begin
            busy = 1'b0;
            txn++;
        end
        if (req_valid && can_push) q.push_back('{req_op1, req_op2});
    endtask

    task automatic check_outputs();
        bit ev, mm;
        ev = busy && e >= resp_edge;
        mm = 1'b0;
`ifdef MULT_DRV_CHECK_EN
        mm = ev && !exp_tmo && exp_prod != 16'(cur_a) * 16'(cur_b);
`endif
        chk("mult_start", 32'(mult_start), 32'(busy && e == d_edge));
        chk("multiplicand", 32'(mult_multiplicand), 32'(cur_a));
        chk("multiplier", 32'(mult_multiplier), 32'(cur_b));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("req_ready", 32'(req_ready), 32'(q.size() < D));
        chk("txn_count", 32'(txn_count), 32'(txn));
        chk("rsp_mismatch", 32'(rsp_mismatch), 32'(mm));
        if (ev) begin
            chk("rsp_product", 32'(rsp_product), 32'(exp_prod));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_tmo));
        end
        if (mult_start) begin
            n_start++;
            if (first_start_e < 0) first_start_e = e;
        end
        if (rsp_valid && first_valid_e < 0) begin
            first_valid_e = e;
            last_prod = rsp_product;
            last_tmo = rsp_timeout;
            last_mm = rsp_mismatch;
        end
    endtask

    task automatic drive_mult();
        int n;
        bit in_win;
        n = e + 1;
        in_win = busy && n >= d_edge + 2 && n <= resp_edge;
        if (busy && n == done_edge) begin
            mult_done = 1'b1;
            mult_product = plan_prod;
        end else if (!in_win && spurious_en && $urandom_range(0, 9) == 0) begin
            mult_done = 1'b1;
            mult_product = 16'($urandom);
        end else begin
            mult_done = 1'b0;
            mult_product = 16'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        e++;
        model_edge();
        @(negedge clk);
        check_outputs();
        drive_mult();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push1(input logic [7:0] a, input logic [7:0] b);
        req_valid = 1'b1;
        req_op1 = a;
        req_op2 = b;
        cycle();
        push_e = e;
        req_valid = 1'b0;
    endtask

    task automatic clear_rec();
        n_start = 0;
        first_start_e = -1;
        first_valid_e = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        mult_done = 1'b0;
        #1;
        chk("rst_start", 32'(mult_start), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_txn", 32'(txn_count), 0);
        chk("rst_op1", 32'(mult_multiplicand), 0);
        chk("rst_op2", 32'(mult_multiplier), 0);
        chk("rst_product", 32'(rsp_product), 0);
        chk("rst_timeout", 32'(rsp_timeout), 0);
        chk("rst_mismatch", 32'(rsp_mismatch), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        q.delete();
        busy = 1'b0;
        txn = '0;
        cur_a = '0;
        cur_b = '0;
        done_edge = -100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready), 1);
    endtask

    initial begin
        int vp, mr_pct, rr_pct;
        vp = 50;
        mr_pct = 80;
        rr_pct = 80;
        do_reset();
        // Single operation: 0x0C * 0x0A, done 8 cycles after START.
        mult_ready = 1'b1;
        rsp_ready = 1'b1;
        fixed_lat = 8;
        clear_rec();
        push1(8'h0C, 8'h0A);
        run(20);
        chk("single_start_lat", 32'(first_start_e - push_e), 1);
        chk("single_valid_lat", 32'(first_valid_e - first_start_e), 9);
        chk("single_nstart", 32'(n_start), 1);
        chk("single_op1", 32'(mult_multiplicand), 32'h0C);
        chk("single_op2", 32'(mult_multiplier), 32'h0A);
        chk("single_prod", 32'(last_prod), 32'h0078);
        chk("single_tmo", 32'(last_tmo), 0);
        chk("single_txn", 32'(txn_count), 1);
        // Fill: five pushes against a stalled multiplier, only four fit.
        mult_ready = 1'b0;
        fixed_lat = 3;
        clear_rec();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_op1 = 8'(8'h10 + i);
            req_op2 = 8'(8'h20 + i);
            cycle();
            if (i == 3) chk("fill_ready_after4", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        mult_ready = 1'b1;
        run(60);
        chk("fill_nstart", 32'(n_start), 4);
        chk("fill_txn", 32'(txn_count), 5);
        chk("fill_last_op1", 32'(mult_multiplicand), 32'h13);
        chk("fill_last_op2", 32'(mult_multiplier), 32'h23);
        // Timeout: done never arrives.
        fixed_lat = 1000;
        clear_rec();
        push1(8'h33, 8'h44);
        run(80);
        chk("tmo_valid_lat", 32'(first_valid_e - first_start_e), 32'(1 + T));
        chk("tmo_flag", 32'(last_tmo), 1);
        chk("tmo_prod", 32'(last_prod), 0);
        chk("tmo_txn", 32'(txn_count), 6);
        // Backpressure: response held, no second dispatch until released.
        fixed_lat = 2;
        rsp_ready = 1'b0;
        clear_rec();
        push1(8'h05, 8'h07);
        push1(8'h09, 8'h0B);
        run(15);
        chk("bp_nstart", 32'(n_start), 1);
        chk("bp_valid", 32'(rsp_valid), 1);
        chk("bp_prod", 32'(rsp_product), 32'h0023);
        rsp_ready = 1'b1;
        run(20);
        chk("bp_nstart_after", 32'(n_start), 2);
        chk("bp_txn", 32'(txn_count), 8);
        // Reset while waiting with two entries queued.
        fixed_lat = 1000;
        push1(8'h01, 8'h02);
        push1(8'h03, 8'h04);
        push1(8'h05, 8'h06);
        run(5);
        do_reset();
        clear_rec();
        run(20);
        chk("rstmid_nstart", 32'(n_start), 0);
        chk("rstmid_txn", 32'(txn_count), 0);
`ifdef MULT_DRV_CHECK_EN
        fixed_lat = 4;
        fixed_prod = 16'hFE00;
        clear_rec();
        push1(8'hFF, 8'hFF);
        run(15);
        chk("chk_mismatch_bad", 32'(last_mm), 1);
        fixed_prod = 16'hFE01;
        clear_rec();
        push1(8'hFF, 8'hFF);
        run(15);
        chk("chk_mismatch_good", 32'(last_mm), 0);
`endif
        // Randomized traffic with spurious done pulses outside the wait window.
        fixed_lat = -1;
        fixed_prod = -1;
        spurious_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                vp = int'($urandom_range(10, 90));
                mr_pct = int'($urandom_range(20, 100));
                rr_pct = int'($urandom_range(10, 100));
            end
            if (i == 2000) do_reset();
            req_valid = int'($urandom_range(0, 99)) < vp;
            req_op1 = 8'($urandom);
            req_op2 = 8'($urandom);
            mult_ready = int'($urandom_range(0, 99)) < mr_pct;
            rsp_ready = int'($urandom_range(0, 99)) < rr_pct;
            cycle();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/mult_stim_driver.md
# mult_stim_driver

Synthesizable stimulus driver for the shift-add multiplier. It accepts operand pairs on a valid/ready request port and buffers them in a small FIFO. It issues each pair to the multiplier with a single-cycle start pulse, waits for done (or a timeout), and returns the product on a valid/ready response port. It drives the same start/operand interface that the grader's transaction monitor observes, and is the on-chip source of multiplier traffic for self-test and bring-up.

## Interface
Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- DEPTH, 4, request FIFO entries (power of two, >= 2).
- TIMEOUT, 64, max WAIT cycles before giving up (>= 2).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request operand pair present.
- req_ready  out  1  FIFO can accept (= !full).
- req_op1  in  WIDTH  multiplicand.
- req_op2  in  WIDTH  multiplier.
- mult_ready  in  1  multiplier idle, may accept start.
- mult_start  out  1  start pulse to multiplier.
- mult_multiplicand  out  WIDTH  operand 1 to multiplier.
- mult_multiplier  out  WIDTH  operand 2 to multiplier.
- mult_done  in  1  multiplier result valid.
- mult_product  in  2*WIDTH  multiplier result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_product  out  2*WIDTH  captured product (0 on timeout).
- rsp_timeout  out  1  response produced by timeout.
- rsp_mismatch  out  1  product differs from expected (see Configuration).
- txn_count  out  16  completed responses, wraps at 2^16.

## Operation
- FIFO: registered count; push when req_valid & req_ready; pop only in IDLE dispatch. No fall-through: a push into an empty FIFO is poppable the next cycle. When full, req_ready=0 and pushes are ignored.
- FSM states: IDLE, START, WAIT, RESP.
  - IDLE: if FIFO non-empty and mult_ready=1, pop head into operand registers and go to START. Otherwise remain.
  - START: mult_start=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: if mult_done=1, capture mult_product, set rsp_timeout=0, and go to RESP. Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no done, set product=0 and rsp_timeout=1, and go to RESP.
  - RESP: rsp_valid=1, with all rsp_* outputs stable. On rsp_ready=1, increment txn_count and go to IDLE.
- Operand outputs hold their registered values from START until the next dispatch. They do not change in WAIT or RESP.
- mult_done outside WAIT is ignored.
- Pushes are accepted in every state, independent of the FSM.

## Timing
- Reset values (applied asynchronously on reset assertion): state=IDLE, FIFO empty, mult_start=0, operands=0, rsp_valid=0, rsp_product=0, rsp_timeout=0, rsp_mismatch=0, txn_count=0. req_ready becomes 1 once reset deasserts.
- Push-to-start latency with an empty FIFO, an idle FSM and mult_ready=1: push at edge N, pop at N+1, mult_start high during cycle N+1..N+2.
- Done sampled at edge M puts rsp_valid high from M. Back-to-back: rsp_ready at edge R puts the FSM in IDLE, and the earliest next mult_start follows one cycle later.
- Timeout: the response is raised exactly TIMEOUT cycles after leaving START, counting WAIT cycles.
- If mult_done coincides with the timeout cycle, done wins and rsp_timeout=0.
- Reset mid-operation: in-flight transaction and FIFO contents are discarded. mult_start drops immediately, and txn_count is cleared.

## Configuration
- MULT_DRV_CHECK_EN defined: at dispatch, the block registers expected = op1*op2 (unsigned, 2*WIDTH). In RESP, rsp_mismatch = !rsp_timeout & (rsp_product != expected).
- Not defined: no expected register and no multiplier. rsp_mismatch is tied to 0.

## Test plan
- Single op: push (0x0C, 0x0A), model done after 8 cycles with 0x0078 -> one mult_start pulse with operands 0x0C/0x0A; rsp_product=0x0078, rsp_timeout=0, txn_count=1.
- Fill: hold mult_ready=0 and push 5 pairs -> 4 accepted, req_ready=0 after the 4th. Release mult_ready -> 4 responses in push order.
- Timeout: never assert done, TIMEOUT=64 -> rsp_valid exactly 64 cycles after START, with rsp_timeout=1 and rsp_product=0.
- Backpressure: hold rsp_ready=0 for 10 cycles -> response stable, no new mult_start. On release, next dispatch proceeds.
- Reset mid-WAIT with 2 queued entries -> all outputs reset, FIFO empty, no start after deassert until a new push.
- With MULT_DRV_CHECK_EN: push (0xFF, 0xFF), model returns 0xFE00 -> rsp_mismatch=1. Model returns 0xFE01 -> rsp_mismatch=0.
